// File: rtl/lshifup_sync_bank.sv
// rtl/lshifup_sync_bank.sv - LV->3V3 level-shift synchroniser bank with power-sequenced isolation clamp
module lshifup_sync_bank #(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter int               WAKE_CYCLES = 4,
   parameter logic [WIDTH-1:0] CLAMP_VAL   = '0
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic             EN,
   input  logic             PG_LO,
   input  logic             FORCE_ISO,
   output logic [WIDTH-1:0] Y,
   output logic             ISO_ACT,
   output logic             READY
);

   localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_ISO  = 2'd0,
      ST_WAKE = 2'd1,
      ST_PASS = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] a_sync;
   logic [SYNC_STAGES-1:0]            en_sync;
   logic [SYNC_STAGES-1:0]            pg_sync;
   logic [WIDTH-1:0]                  a_s;
   logic                              en_s;
   logic                              pg_s;
   logic                              abort;
   state_t                            state;
   logic [CW-1:0]                     wake_cnt;

   assign a_s  = a_sync[SYNC_STAGES-1];
   assign en_s = en_sync[SYNC_STAGES-1];
   assign pg_s = pg_sync[SYNC_STAGES-1];

   // Any loss of enable/power-good or a forced isolate drops back to ISO.
   assign abort = !en_s || !pg_s || FORCE_ISO;

   // Data chains run in every state so they are already flushed when PASS opens.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         a_sync <= '0;
      end else begin
         a_sync[0] <= A;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            a_sync[i] <= a_sync[i-1];
         end
      end
   end

   // Control chains for the asynchronous enable and power-good inputs.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         en_sync <= '0;
         pg_sync <= '0;
      end else begin
         en_sync <= {en_sync[SYNC_STAGES-2:0], EN};
         pg_sync <= {pg_sync[SYNC_STAGES-2:0], PG_LO};
      end
   end

   // Power-sequencing FSM; abort always wins over the WAKE->PASS step.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state    <= ST_ISO;
         wake_cnt <= '0;
      end else begin
         case (state)
            ST_ISO: begin
               wake_cnt <= '0;
               if (en_s && pg_s && !FORCE_ISO) begin
                  state <= ST_WAKE;
               end
            end
            ST_WAKE: begin
               if (abort) begin
                  state    <= ST_ISO;
                  wake_cnt <= '0;
               end else if (wake_cnt == WAKE_LAST) begin
                  state <= ST_PASS;
               end else begin
                  wake_cnt <= wake_cnt + CW'(1);
               end
            end
            ST_PASS: begin
               wake_cnt <= '0;
               if (abort) begin
                  state <= ST_ISO;
               end
            end
            default: begin
               state    <= ST_ISO;
               wake_cnt <= '0;
            end
         endcase
      end
   end

   // Outputs decode from registered state only, so reset clamps Y without a clock.
   assign Y       = (state == ST_PASS) ? a_s : CLAMP_VAL;
   assign ISO_ACT = (state != ST_PASS);
   assign READY   = (state == ST_PASS);

endmodule
